// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control-path pipeline register with load-use hazard detection,
// bubble insertion, branch/jump flush and a saturating bubble counter.
module id_ex_ctrl_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [6:0]            id_opcode_i,
  input  logic                  branch_i,
  input  logic                  jump_i,
  input  logic [1:0]            alu_opmode_i,
  input  logic                  alu_src_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  reg_write_i,
  input  logic                  mem_to_reg_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  flush_i,
  input  logic                  ex_stall_i,
  output logic                  ex_valid_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic [1:0]            ex_alu_opmode_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_to_reg_o,
  output logic [REG_ADDR_W-1:0] ex_rs1_o,
  output logic [REG_ADDR_W-1:0] ex_rs2_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  load_use_stall_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic [1:0] alu_opmode;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  ctrl_t id_ctrl, ex_ctrl;
  logic  uses_rs1, uses_rs2, hazard;

  assign id_ctrl = {branch_i, jump_i, alu_opmode_i, alu_src_i,
                    mem_read_i, mem_write_i, reg_write_i, mem_to_reg_i};

  // Which source fields the ID opcode actually reads
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    if (id_opcode_i == OP_LUI || id_opcode_i == OP_JAL) uses_rs1 = 1'b0;
    if (id_opcode_i == OP_RTYPE || id_opcode_i == OP_STORE || id_opcode_i == OP_BRANCH)
      uses_rs2 = 1'b1;
  end

  // Load in EX whose rd (never x0) feeds a source used by the ID instruction
  assign hazard = id_valid_i & ex_valid_o & ex_ctrl.mem_read & (ex_rd_o != '0) &
                  ((uses_rs1 & (id_rs1_i == ex_rd_o)) | (uses_rs2 & (id_rs2_i == ex_rd_o)));

  // A flush overrides the hazard: the ID instruction is killed anyway, so the
  // front end must advance to the redirect target.
  assign pc_write_o       = ~ex_stall_i & (flush_i | ~hazard);
  assign if_id_write_o    = pc_write_o;
  assign load_use_stall_o = ~ex_stall_i & ~flush_i & hazard;

  // EX register: stall holds, flush/hazard load a bubble, otherwise capture ID
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl      <= '0;
      ex_rs1_o     <= '0;
      ex_rs2_o     <= '0;
      ex_rd_o      <= '0;
      bubble_cnt_o <= '0;
    end else if (ex_stall_i) begin
      ex_valid_o   <= ex_valid_o;
    end else if (flush_i || hazard) begin
      ex_valid_o <= 1'b0;
      ex_ctrl    <= '0;
      ex_rs1_o   <= '0;
      ex_rs2_o   <= '0;
      ex_rd_o    <= '0;
      if (!flush_i && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end else begin
      ex_valid_o <= id_valid_i;
      ex_ctrl    <= id_valid_i ? id_ctrl : '0;
      ex_rs1_o   <= id_rs1_i;
      ex_rs2_o   <= id_rs2_i;
      ex_rd_o    <= id_rd_i;
    end
  end

  assign ex_branch_o     = ex_ctrl.branch;
  assign ex_jump_o       = ex_ctrl.jump;
  assign ex_alu_opmode_o = ex_ctrl.alu_opmode;
  assign ex_alu_src_o    = ex_ctrl.alu_src;
  assign ex_mem_read_o   = ex_ctrl.mem_read;
  assign ex_mem_write_o  = ex_ctrl.mem_write;
  assign ex_reg_write_o  = ex_ctrl.reg_write;
  assign ex_mem_to_reg_o = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: directed vector table, counter saturation and
// async reset sequences, then randomized traffic against a behavioural model.
module tb_id_ex_ctrl_stage;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_JAL = 7'b1101111, OP_R = 7'b0110011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_I = 7'b0010011;
  // ctrl packing: {branch, jump, opmode[1:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg}
  localparam logic [8:0] C_ADDI = 9'b0_0_11_1_0_0_1_0;
  localparam logic [8:0] C_LW   = 9'b0_0_00_1_1_0_1_1;
  localparam logic [8:0] C_ADD  = 9'b0_0_10_0_0_0_1_0;
  localparam logic [8:0] C_LUI  = 9'b0_0_00_1_0_0_1_0;
  localparam logic [8:0] C_SW   = 9'b0_0_00_1_0_1_0_0;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic       in_v = 0, in_flush = 0, in_stall = 0;
  logic [6:0] in_op = '0;
  logic [8:0] in_ctrl = '0;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;

  logic ex_v, ex_br, ex_jp, ex_as, ex_mr, ex_mw, ex_rw, ex_m2r, pcw, ifw, lus;
  logic [1:0] ex_op;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [15:0] cnt;
  logic s_v, s_br, s_jp, s_as, s_mr, s_mw, s_rw, s_m2r, s_pcw, s_ifw, s_lus;
  logic [1:0] s_op;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [1:0] s_cnt;
  logic [8:0] ex_ctrl;
  assign ex_ctrl = {ex_br, ex_jp, ex_op, ex_as, ex_mr, ex_mw, ex_rw, ex_m2r};

  id_ex_ctrl_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(in_v), .id_opcode_i(in_op),
    .branch_i(in_ctrl[8]), .jump_i(in_ctrl[7]), .alu_opmode_i(in_ctrl[6:5]),
    .alu_src_i(in_ctrl[4]), .mem_read_i(in_ctrl[3]), .mem_write_i(in_ctrl[2]),
    .reg_write_i(in_ctrl[1]), .mem_to_reg_i(in_ctrl[0]),
    .id_rs1_i(in_rs1), .id_rs2_i(in_rs2), .id_rd_i(in_rd),
    .flush_i(in_flush), .ex_stall_i(in_stall),
    .ex_valid_o(ex_v), .ex_branch_o(ex_br), .ex_jump_o(ex_jp), .ex_alu_opmode_o(ex_op),
    .ex_alu_src_o(ex_as), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
    .ex_reg_write_o(ex_rw), .ex_mem_to_reg_o(ex_m2r),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .pc_write_o(pcw), .if_id_write_o(ifw), .load_use_stall_o(lus), .bubble_cnt_o(cnt));

  id_ex_ctrl_stage #(.REG_ADDR_W(5), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(in_v), .id_opcode_i(in_op),
    .branch_i(in_ctrl[8]), .jump_i(in_ctrl[7]), .alu_opmode_i(in_ctrl[6:5]),
    .alu_src_i(in_ctrl[4]), .mem_read_i(in_ctrl[3]), .mem_write_i(in_ctrl[2]),
    .reg_write_i(in_ctrl[1]), .mem_to_reg_i(in_ctrl[0]),
    .id_rs1_i(in_rs1), .id_rs2_i(in_rs2), .id_rd_i(in_rd),
    .flush_i(in_flush), .ex_stall_i(in_stall),
    .ex_valid_o(s_v), .ex_branch_o(s_br), .ex_jump_o(s_jp), .ex_alu_opmode_o(s_op),
    .ex_alu_src_o(s_as), .ex_mem_read_o(s_mr), .ex_mem_write_o(s_mw),
    .ex_reg_write_o(s_rw), .ex_mem_to_reg_o(s_m2r),
    .ex_rs1_o(s_rs1), .ex_rs2_o(s_rs2), .ex_rd_o(s_rd),
    .pc_write_o(s_pcw), .if_id_write_o(s_ifw), .load_use_stall_o(s_lus), .bubble_cnt_o(s_cnt));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what EX holds and how many load-use bubbles were counted
  logic       m_v;
  logic [8:0] m_ctrl;
  logic [4:0] m_rs1, m_rs2, m_rd;
  int         m_cnt, m_cnt_sat;
  logic       smp_pcw, smp_lus;

  task automatic model_reset();
    m_v = 0; m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_cnt = 0; m_cnt_sat = 0;
  endtask

  function automatic bit model_hazard();
    bit r1 = !(in_op inside {OP_LUI, OP_JAL});
    bit r2 = in_op inside {OP_R, OP_S, OP_B};
    if (!(in_v && m_v && m_ctrl[3] && m_rd != 0)) return 0;
    return (r1 && in_rs1 == m_rd) || (r2 && in_rs2 == m_rd);
  endfunction

  task automatic check_regs();
    check("ex_valid", {31'd0, ex_v}, {31'd0, m_v});
    check("ex_ctrl", {23'd0, ex_ctrl}, {23'd0, m_ctrl});
    check("ex_rs1", {27'd0, ex_rs1}, {27'd0, m_rs1});
    check("ex_rs2", {27'd0, ex_rs2}, {27'd0, m_rs2});
    check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    check("bubble_cnt", {16'd0, cnt}, m_cnt);
    check("bubble_cnt_sat", {30'd0, s_cnt}, m_cnt_sat);
  endtask

  // One clock: drive ID at negedge, check enables, then check EX after the edge
  task automatic step(input logic [6:0] op, input logic v, input logic [8:0] c,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic fl, input logic st);
    bit hz, e_pcw, e_lus;
    @(negedge clk);
    in_op = op; in_v = v; in_ctrl = c; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_flush = fl; in_stall = st;
    #1;
    hz = model_hazard();
    e_pcw = !st && (fl || !hz);
    e_lus = !st && !fl && hz;
    smp_pcw = pcw; smp_lus = lus;
    check("pc_write", {31'd0, pcw}, {31'd0, e_pcw});
    check("if_id_write", {31'd0, ifw}, {31'd0, e_pcw});
    check("load_use_stall", {31'd0, lus}, {31'd0, e_lus});
    @(posedge clk);
    if (!st) begin
      if (fl || hz) begin
        m_v = 0; m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        if (!fl) begin
          m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
          m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : m_cnt_sat;
        end
      end else begin
        m_v = v; m_ctrl = v ? c : 9'd0; m_rs1 = r1; m_rs2 = r2; m_rd = rd;
      end
    end
    #1;
    check_regs();
  endtask

  typedef struct {
    logic [6:0] op; logic v; logic [8:0] c; logic [4:0] rs1, rs2, rd; logic fl, st;
    logic pcw, lus, ev; logic [8:0] ectrl; logic [4:0] erd; int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [6:0] op, logic v, logic [8:0] c, logic [4:0] rs1,
                              logic [4:0] rs2, logic [4:0] rd, logic fl, logic st,
                              logic pcw_e, logic lus_e, logic ev, logic [8:0] ectrl,
                              logic [4:0] erd, int cnt_e);
    vec_t t;
    t.op = op; t.v = v; t.c = c; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.fl = fl; t.st = st;
    t.pcw = pcw_e; t.lus = lus_e; t.ev = ev; t.ectrl = ectrl; t.erd = erd; t.cnt = cnt_e;
    return t;
  endfunction

  initial begin
    // op, v, ctrl, rs1, rs2, rd, flush, stall | pcw, lus | ex_valid, ex_ctrl, ex_rd, cnt
    tbl.push_back(mk(OP_I,  1, C_ADDI, 1, 0,  5, 0, 0, 1, 0, 1, C_ADDI,  5, 0)); // ADDI
    tbl.push_back(mk(OP_LD, 1, C_LW,   2, 0,  5, 0, 0, 1, 0, 1, C_LW,    5, 0)); // LW x5
    tbl.push_back(mk(OP_R,  1, C_ADD,  3, 5,  6, 0, 0, 0, 1, 0, 9'd0,    0, 1)); // use rs2 -> bubble
    tbl.push_back(mk(OP_R,  1, C_ADD,  3, 5,  6, 0, 0, 1, 0, 1, C_ADD,   6, 1)); // ADD enters
    tbl.push_back(mk(OP_LD, 1, C_LW,   2, 0,  5, 0, 0, 1, 0, 1, C_LW,    5, 1));
    tbl.push_back(mk(OP_LUI,1, C_LUI,  5, 0,  8, 0, 0, 1, 0, 1, C_LUI,   8, 1)); // LUI ignores rs1
    tbl.push_back(mk(OP_LD, 1, C_LW,   1, 0,  0, 0, 0, 1, 0, 1, C_LW,    0, 1)); // LW x0
    tbl.push_back(mk(OP_R,  1, C_ADD,  0, 0,  9, 0, 0, 1, 0, 1, C_ADD,   9, 1)); // x0 no hazard
    tbl.push_back(mk(OP_LD, 1, C_LW,   1, 0,  7, 0, 0, 1, 0, 1, C_LW,    7, 1));
    tbl.push_back(mk(OP_S,  1, C_SW,   1, 7,  0, 1, 0, 1, 0, 0, 9'd0,    0, 1)); // flush wins
    tbl.push_back(mk(OP_I,  1, C_ADDI, 1, 0,  5, 0, 1, 0, 0, 0, 9'd0,    0, 1)); // stall x3
    tbl.push_back(mk(OP_R,  1, C_ADD,  2, 3,  6, 0, 1, 0, 0, 0, 9'd0,    0, 1));
    tbl.push_back(mk(OP_LD, 1, C_LW,   3, 0, 10, 0, 1, 0, 0, 0, 9'd0,    0, 1));
    tbl.push_back(mk(OP_I,  1, C_ADDI, 1, 0, 12, 0, 0, 1, 0, 1, C_ADDI, 12, 1)); // release
    tbl.push_back(mk(OP_R,  0, C_ADD,  3, 5,  3, 0, 0, 1, 0, 0, 9'd0,    3, 1)); // invalid ID
    tbl.push_back(mk(OP_LD, 1, C_LW,   1, 0,  4, 0, 0, 1, 0, 1, C_LW,    4, 1));
    tbl.push_back(mk(OP_R,  1, C_ADD,  4, 0,  6, 1, 1, 0, 0, 1, C_LW,    4, 1)); // stall beats flush
    tbl.push_back(mk(OP_R,  1, C_ADD,  4, 0,  6, 0, 0, 0, 1, 0, 9'd0,    0, 2)); // hazard

    // reset state
    model_reset();
    #12;
    check("reset_valid", {31'd0, ex_v}, 32'd0);
    check("reset_ctrl", {23'd0, ex_ctrl}, 32'd0);
    check("reset_rd", {27'd0, ex_rd}, 32'd0);
    check("reset_cnt", {16'd0, cnt}, 32'd0);
    check("reset_pcw", {31'd0, pcw}, 32'd1);
    @(negedge clk); rst_n = 1;

    foreach (tbl[i]) begin
      step(tbl[i].op, tbl[i].v, tbl[i].c, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].fl, tbl[i].st);
      check($sformatf("vec%0d_pcw", i), {31'd0, smp_pcw}, {31'd0, tbl[i].pcw});
      check($sformatf("vec%0d_lus", i), {31'd0, smp_lus}, {31'd0, tbl[i].lus});
      check($sformatf("vec%0d_valid", i), {31'd0, ex_v}, {31'd0, tbl[i].ev});
      check($sformatf("vec%0d_ctrl", i), {23'd0, ex_ctrl}, {23'd0, tbl[i].ectrl});
      check($sformatf("vec%0d_rd", i), {27'd0, ex_rd}, {27'd0, tbl[i].erd});
      check($sformatf("vec%0d_cnt", i), {16'd0, cnt}, tbl[i].cnt);
    end

    // four more load-use stalls: narrow counter pins at 3, wide one keeps counting
    for (int k = 0; k < 4; k++) begin
      step(OP_LD, 1, C_LW, 1, 0, 5, 0, 0);
      step(OP_R, 1, C_ADD, 2, 5, 6, 0, 0);
      step(OP_R, 1, C_ADD, 2, 5, 6, 0, 0);
    end
    check("sat_cnt_wide", {16'd0, cnt}, 32'd6);
    check("sat_cnt_narrow", {30'd0, s_cnt}, 32'd3);

    // async reset in the middle of a load-use stall cycle
    step(OP_LD, 1, C_LW, 1, 0, 5, 0, 0);
    @(negedge clk);
    in_op = OP_R; in_v = 1; in_ctrl = C_ADD; in_rs1 = 2; in_rs2 = 5; in_rd = 6;
    in_flush = 0; in_stall = 0;
    #1;
    check("pre_reset_lus", {31'd0, lus}, 32'd1);
    #1 rst_n = 0;
    #1;
    check("midrst_valid", {31'd0, ex_v}, 32'd0);
    check("midrst_ctrl", {23'd0, ex_ctrl}, 32'd0);
    check("midrst_rd", {27'd0, ex_rd}, 32'd0);
    check("midrst_cnt", {16'd0, cnt}, 32'd0);
    check("midrst_cnt_sat", {30'd0, s_cnt}, 32'd0);
    check("midrst_pcw", {31'd0, pcw}, 32'd1);
    check("midrst_lus", {31'd0, lus}, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1;

    // randomized traffic with small register range so hazards are frequent
    for (int k = 0; k < 500; k++) begin
      logic [6:0] op;
      logic [8:0] c;
      case ($urandom_range(0, 7))
        0: op = OP_LUI;  1: op = OP_JAL; 2: op = OP_R;  3: op = OP_S;
        4: op = OP_B;    5: op = OP_LD;  6: op = OP_I;  default: op = 7'($urandom);
      endcase
      c = 9'($urandom);
      c[3] = ($urandom_range(0, 1) == 0);
      step(op, $urandom_range(0, 7) != 0, c, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
